// File: rtl/auth_resp_tx_if.sv
// Port bundle for auth_resp_tx: the responder capture handshake plus the byte stream toward the transport.
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

interface auth_resp_tx_if #(
    parameter int MSG_LEN = `MSG_LEN
);
    // Capture: resp_req_in is a level; ack_out pulses for one cycle when auth_msg_in is taken.
    // Stream: a byte moves on every posedge with tx_valid & tx_ready; once tx_valid is high,
    // tx_data/tx_sop/tx_eop hold until that edge, and tx_valid never depends on tx_ready.
    logic               resp_req_in;
    logic [MSG_LEN-1:0] auth_msg_in;
    logic               ack_out;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_sop;
    logic               tx_eop;
    logic               tx_ready;

    modport master (
        input  resp_req_in,
        input  auth_msg_in,
        input  tx_ready,
        output ack_out,
        output tx_data,
        output tx_valid,
        output tx_sop,
        output tx_eop
    );

    modport slave (
        output resp_req_in,
        output auth_msg_in,
        output tx_ready,
        input  ack_out,
        input  tx_data,
        input  tx_valid,
        input  tx_sop,
        input  tx_eop
    );
endinterface

// File: rtl/auth_resp_tx.sv
// Transmit stage: captures one response message, then streams it MSB byte first with a stall timeout.
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

module auth_resp_tx #(
    parameter int MSG_LEN        = `MSG_LEN,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    auth_resp_tx_if.master      bus,
    output logic                busy,
    output logic [7:0]          last_msg_type,
    output logic                timeout_err,
    output logic [1:0]          state_o
);
    localparam int NBYTES  = MSG_LEN / 8;
    localparam int CNT_W   = $clog2(NBYTES);
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_SEND    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [MSG_LEN-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           type_q, type_d;
    logic                 valid_q, valid_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic                 ack_q, ack_d;
    logic                 to_q, to_d;
    logic                 busy_q, busy_d;

    logic handshake;
    logic stalled;
    logic last_byte;
    logic stall_expire;

    assign handshake    = valid_q & bus.tx_ready;
    assign stalled      = valid_q & ~bus.tx_ready;
    assign last_byte    = (cnt_q == CNT_W'(NBYTES - 1));
    assign stall_expire = (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            data_q  <= '0;
            type_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            data_q  <= data_d;
            type_q  <= type_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.resp_req_in) state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (handshake && last_byte) begin
                    state_d = S_RELEASE;
                end else if (stalled && stall_expire) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Holding here until the request drops keeps one message from being taken twice.
                if (!bus.resp_req_in) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        data_d  = data_q;
        type_d  = type_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        ack_d   = 1'b0;
        to_d    = 1'b0;
        busy_d  = (state_d != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (bus.resp_req_in) begin
                    shift_d = bus.auth_msg_in;
                    type_d  = bus.auth_msg_in[MSG_LEN-9 -: 8];
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    stall_d = '0;
                end
            end
            S_ACK: begin
                data_d  = shift_q[MSG_LEN-1 -: 8];
                shift_d = {shift_q[MSG_LEN-9:0], 8'h00};
                valid_d = 1'b1;
                sop_d   = 1'b1;
                eop_d   = 1'b0;
                cnt_d   = '0;
                stall_d = '0;
            end
            S_SEND: begin
                if (handshake) begin
                    stall_d = '0;
                    if (last_byte) begin
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        data_d  = '0;
                    end else begin
                        data_d  = shift_q[MSG_LEN-1 -: 8];
                        shift_d = {shift_q[MSG_LEN-9:0], 8'h00};
                        cnt_d   = cnt_q + 1'b1;
                        sop_d   = 1'b0;
                        eop_d   = (cnt_q == CNT_W'(NBYTES - 2));
                    end
                end else if (stalled) begin
                    // The abort lands on the stalled cycle that would make the count reach the limit.
                    if (stall_expire) begin
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        data_d  = '0;
                        shift_d = '0;
                        stall_d = '0;
                        to_d    = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
            end
            default: begin
            end
        endcase
    end

    assign bus.ack_out    = ack_q;
    assign bus.tx_data    = data_q;
    assign bus.tx_valid   = valid_q;
    assign bus.tx_sop     = sop_q;
    assign bus.tx_eop     = eop_q;
    assign busy           = busy_q;
    assign last_msg_type  = type_q;
    assign timeout_err    = to_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_auth_resp_tx.sv
// Bench for auth_resp_tx: message-level reference model, byte scoreboard and directed scenarios.
module tb_auth_resp_tx;
    localparam int MSG_LEN = 64;
    localparam int NB      = MSG_LEN / 8;
    localparam int TO      = 4;

    localparam int PH_IDLE   = 0;
    localparam int PH_ACK    = 1;
    localparam int PH_STREAM = 2;
    localparam int PH_HOLD   = 3;

    localparam logic [63:0] M1 = 64'h0181_0000_A55A_C33C;
    localparam logic [63:0] M2 = 64'h0183_1122_3344_5566;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic       timeout_err;
    logic [7:0] last_msg_type;
    logic [1:0] state_o;

    auth_resp_tx_if #(.MSG_LEN(MSG_LEN)) bus ();

    auth_resp_tx #(.MSG_LEN(MSG_LEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .last_msg_type (last_msg_type),
        .timeout_err   (timeout_err),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ack_cnt  = 0;
    int to_cnt   = 0;
    int sop_hs   = 0;
    int eop_hs   = 0;

    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: message as a byte array, a position in it, and a stall tally.
    int         m_phase = PH_IDLE;
    int         m_idx   = 0;
    int         m_stall = 0;
    logic       m_ack   = 1'b0;
    logic       m_to    = 1'b0;
    logic [7:0] m_type  = 8'h00;
    logic [7:0] m_msg [NB];

    initial begin : monitor
        logic               s_reset, s_req, s_ready;
        logic [MSG_LEN-1:0] s_msg;
        logic [7:0]         q;
        forever begin
            @(negedge clk);
            chk("ack_out", 64'(bus.ack_out), 64'(m_ack));
            chk("tx_valid", 64'(bus.tx_valid), 64'(m_phase == PH_STREAM));
            if (m_phase == PH_STREAM) begin
                chk("tx_data", 64'(bus.tx_data), 64'(m_msg[m_idx]));
                chk("tx_sop", 64'(bus.tx_sop), 64'(m_idx == 0));
                chk("tx_eop", 64'(bus.tx_eop), 64'(m_idx == NB - 1));
            end else begin
                chk("tx_sop_idle", 64'(bus.tx_sop), 64'd0);
                chk("tx_eop_idle", 64'(bus.tx_eop), 64'd0);
            end
            chk("busy", 64'(busy), 64'(m_phase != PH_IDLE));
            chk("timeout_err", 64'(timeout_err), 64'(m_to));
            chk("last_msg_type", 64'(last_msg_type), 64'(m_type));
            if (bus.ack_out) ack_cnt++;
            if (timeout_err) to_cnt++;

            s_reset = reset;
            s_req   = bus.resp_req_in;
            s_ready = bus.tx_ready;
            s_msg   = bus.auth_msg_in;
            if (!s_reset && bus.tx_valid && s_ready) begin
                if (bus.tx_sop) sop_hs++;
                if (bus.tx_eop) eop_hs++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_extra: got byte %0h, required no byte", bus.tx_data);
                end else begin
                    q = exp_q.pop_front();
                    chk("sb_byte", 64'(bus.tx_data), 64'(q));
                end
            end

            @(posedge clk);
            if (s_reset) begin
                m_phase = PH_IDLE;
                m_ack   = 1'b0;
                m_to    = 1'b0;
                m_type  = 8'h00;
                m_idx   = 0;
                m_stall = 0;
            end else begin
                m_ack = 1'b0;
                m_to  = 1'b0;
                case (m_phase)
                    PH_IDLE: begin
                        if (s_req) begin
                            for (int i = 0; i < NB; i++) m_msg[i] = s_msg[MSG_LEN-1-8*i -: 8];
                            m_type  = m_msg[1];
                            m_ack   = 1'b1;
                            m_phase = PH_ACK;
                        end
                    end
                    PH_ACK: begin
                        m_phase = PH_STREAM;
                        m_idx   = 0;
                        m_stall = 0;
                    end
                    PH_STREAM: begin
                        if (s_ready) begin
                            m_idx++;
                            m_stall = 0;
                            if (m_idx == NB) m_phase = PH_HOLD;
                        end else begin
                            m_stall++;
                            if (m_stall == TO) begin
                                m_to    = 1'b1;
                                m_phase = PH_HOLD;
                            end
                        end
                    end
                    PH_HOLD: begin
                        if (!s_req) m_phase = PH_IDLE;
                    end
                    default: m_phase = PH_IDLE;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [63:0] m, input int n);
        logic [63:0] t;
        t = m;
        for (int i = 0; i < n; i++) exp_q.push_back(t[63-8*i -: 8]);
    endtask

    task automatic start_req(input logic [63:0] msg, input bit hold, output int ack_at);
        bus.auth_msg_in = msg;
        bus.resp_req_in = 1'b1;
        ack_at = -1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus.ack_out) begin
                ack_at = cyc;
                break;
            end
        end
        if (ack_at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_wait: ack_out=0 for 10 cycles, required 1");
        end
        if (!hold) bus.resp_req_in = 1'b0;
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0 repeating. Returns once tx_valid falls.
    task automatic stream(input int mode, input int stop_at, input int abort_stalls,
                          output int accepted, output int stalls);
        bit seen, vnow, r;
        seen     = 1'b0;
        accepted = 0;
        stalls   = 0;
        for (int n = 0; n < 100; n++) begin
            vnow = bus.tx_valid;
            if (vnow) seen = 1'b1;
            if (seen && !vnow) return;
            if (abort_stalls > 0 && stalls >= abort_stalls) return;
            r = (mode == 0) ? 1'b1 : (n % 3 == 0);
            if (stop_at >= 0 && accepted >= stop_at) r = 1'b0;
            bus.tx_ready = r;
            tick();
            if (vnow && r) accepted++;
            if (vnow && !r) stalls++;
        end
        n_checks++;
        n_errors++;
        $display("FAIL stream_wait: tx_valid still %0b after 100 cycles, required 0", bus.tx_valid);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin : main
        int a1, a2, acc, st;
        logic [7:0] t1_bytes [NB];
        t1_bytes = '{8'h01, 8'h81, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};

        reset           = 1'b1;
        bus.resp_req_in = 1'b0;
        bus.auth_msg_in = '0;
        bus.tx_ready    = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_data", 64'(bus.tx_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_type", 64'(last_msg_type), 64'd0);
        reset = 1'b0;
        tick();

        // Basic transfer
        for (int i = 0; i < NB; i++) exp_q.push_back(t1_bytes[i]);
        start_req(M1, 1'b0, a1);
        chk("t1_type", 64'(last_msg_type), 64'h81);
        chk("t1_busy_cap", 64'(busy), 64'd1);
        stream(0, -1, 0, acc, st);
        chk("t1_accepted", 64'(acc), 64'd8);
        chk("t1_stalls", 64'(st), 64'd0);
        tick();
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_ack_cnt", 64'(ack_cnt), 64'd1);
        chk("t1_sop_cnt", 64'(sop_hs), 64'd1);
        chk("t1_eop_cnt", 64'(eop_hs), 64'd1);
        chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure
        for (int i = 0; i < NB; i++) exp_q.push_back(t1_bytes[i]);
        start_req(M1, 1'b0, a1);
        stream(1, -1, 0, acc, st);
        chk("t2_accepted", 64'(acc), 64'd8);
        chk("t2_stalled", 64'(st > 0), 64'd1);
        tick();
        chk("t2_no_timeout", 64'(to_cnt), 64'd0);
        chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Timeout after byte 2
        push_bytes(64'h0181_0000_0000_0000, 3);
        start_req(M1, 1'b0, a1);
        stream(0, 3, 0, acc, st);
        chk("t3_accepted", 64'(acc), 64'd3);
        chk("t3_stalls", 64'(st), 64'd4);
        chk("t3_timeout_pulse", 64'(timeout_err), 64'd1);
        chk("t3_state_release", 64'(state_o), 64'd3);
        tick();
        chk("t3_timeout_drop", 64'(timeout_err), 64'd0);
        chk("t3_to_cnt", 64'(to_cnt), 64'd1);
        chk("t3_idle", 64'(busy), 64'd0);
        bus.tx_ready = 1'b1;

        // Request held high well past the message
        for (int i = 0; i < NB; i++) exp_q.push_back(t1_bytes[i]);
        start_req(M1, 1'b1, a1);
        stream(0, -1, 0, acc, st);
        repeat (20) tick();
        chk("t4_state_release", 64'(state_o), 64'd3);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_ack_cnt", 64'(ack_cnt), 64'd4);
        bus.resp_req_in = 1'b0;
        tick();
        chk("t4_state_idle", 64'(state_o), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        tick();
        chk("t4_ack_cnt_after", 64'(ack_cnt), 64'd4);

        // Reset while byte 4 is stalled
        push_bytes(M1, 4);
        start_req(M1, 1'b0, a1);
        stream(0, 4, 2, acc, st);
        chk("t5_accepted", 64'(acc), 64'd4);
        chk("t5_data_held", 64'(bus.tx_data), 64'hA5);
        reset = 1'b1;
        tick();
        chk("t5_valid", 64'(bus.tx_valid), 64'd0);
        chk("t5_sop", 64'(bus.tx_sop), 64'd0);
        chk("t5_eop", 64'(bus.tx_eop), 64'd0);
        chk("t5_data", 64'(bus.tx_data), 64'd0);
        chk("t5_ack", 64'(bus.ack_out), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_type", 64'(last_msg_type), 64'd0);
        chk("t5_state", 64'(state_o), 64'd0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < NB; i++) exp_q.push_back(t1_bytes[i]);
        start_req(M1, 1'b0, a1);
        tick();
        chk("t5_restart_sop", 64'(bus.tx_sop), 64'd1);
        chk("t5_restart_byte0", 64'(bus.tx_data), 64'h01);
        stream(0, -1, 0, acc, st);
        chk("t5_restart_accepted", 64'(acc), 64'd8);
        tick();

        // Back-to-back messages
        for (int i = 0; i < NB; i++) exp_q.push_back(t1_bytes[i]);
        start_req(M1, 1'b0, a1);
        chk("t6_type1", 64'(last_msg_type), 64'h81);
        stream(0, -1, 0, acc, st);
        tick();
        exp_q.push_back(8'h01); exp_q.push_back(8'h83); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        start_req(M2, 1'b0, a2);
        chk("t6_type2", 64'(last_msg_type), 64'h83);
        chk("t6_gap", 64'(a2 - a1), 64'd11);
        stream(0, -1, 0, acc, st);
        chk("t6_accepted2", 64'(acc), 64'd8);
        tick();
        chk("t6_idle", 64'(busy), 64'd0);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
